imem_loader: RTL and testbench

Boot-time program loader that writes a byte stream into the instruction memory. It receives a length-prefixed, little-endian byte stream over a valid/ready handshake, packs each 4 bytes into a 32-bit instruction word and issues one write per word at ascending word-aligned addresses. While loading, it holds the CPU in reset. It is the write-side counterpart to the read-only fetch port (`pc` → `inst`).

---
 rtl/imem_loader_pkg.sv | 25 ++
 rtl/imem_loader_byte_packer.sv | 31 +++
 rtl/imem_loader.sv | 148 ++++++++++++++
 tb/tb_imem_loader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    // Loader control states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_DONE,
        ST_ERR
    } state_t;

    // Header is a 32-bit little-endian word count.
    localparam int HDR_BYTES  = 4;
    // Each instruction word arrives as four little-endian bytes.
    localparam int WORD_BYTES = 4;
    // Width of the byte-within-word index.
    localparam int IDX_W      = $clog2(WORD_BYTES);

    // True when the given byte index is the final byte of a group of n bytes.
    function automatic logic is_last_byte(input logic [IDX_W-1:0] idx, input int n);
        return idx == IDX_W'(n - 1);
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler shared by header and data phases.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             accept,
    input  logic [7:0]       byte_in,
    input  logic [IDX_W-1:0] idx,
    output logic [31:0]      word,
    output logic             word_full
);

    logic [31:0] asm_q;

    // Shift each accepted byte in from the top so the first byte ends up in bits [7:0].
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q <= '0;
        end else if (accept) begin
            asm_q <= {byte_in, asm_q[31:8]};
        end
    end

    // The complete word is visible combinationally while its last byte is being accepted,
    // so the consumer can register it on the same edge.
    assign word      = {byte_in, asm_q[31:8]};
    assign word_full = accept && is_last_byte(idx, WORD_BYTES);

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: length-prefixed byte stream -> 32-bit instruction memory writes.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          ARRAY_SIZE = 100,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam logic [31:0] MAX_WORDS = 32'(ARRAY_SIZE);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] byte_idx;
    logic [31:0]      word_idx;
    logic [31:0]      word_cnt;
    logic             in_load;
    logic             accept;
    logic             enter_hdr;
    logic             last_word;
    logic [31:0]      asm_word;
    logic             word_full;

    // Stream is consumed only while loading; derived from state alone to keep the
    // handshake free of combinational loops.
    assign in_load    = (state == ST_HDR) || (state == ST_DATA);
    assign byte_ready = in_load;
    assign cpu_hold   = in_load;
    assign accept     = byte_valid && byte_ready;
    assign last_word  = (word_idx == (word_cnt - 32'd1));

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .accept    (accept),
        .byte_in   (byte_data),
        .idx       (byte_idx),
        .word      (asm_word),
        .word_full (word_full)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and status outputs.
    // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        enter_hdr = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_HDR;
                    enter_hdr = 1'b1;
                end
            end
            ST_HDR: begin
                if (word_full) begin
                    if (asm_word == 32'd0) begin
                        state_nxt = ST_DONE;
                    end else if (asm_word > MAX_WORDS) begin
                        state_nxt = ST_ERR;
                    end else begin
                        state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (word_full && last_word) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_nxt = ST_HDR;
                    enter_hdr = 1'b1;
                end
            end
            ST_ERR: begin
                error = 1'b1;
                if (start) begin
                    state_nxt = ST_HDR;
                    enter_hdr = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Byte index, word index and latched header word count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx <= '0;
            word_idx <= '0;
            word_cnt <= '0;
        end else if (enter_hdr) begin
            byte_idx <= '0;
            word_idx <= '0;
        end else if (accept) begin
            byte_idx <= byte_idx + 1'b1;
            if (word_full && (state == ST_HDR)) begin
                word_cnt <= asm_word;
            end
            if (word_full && (state == ST_DATA)) begin
                word_idx <= word_idx + 32'd1;
            end
        end
    end

    // Registered write port: one-cycle strobe, address/data hold until the next write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            we <= 1'b0;
            if (word_full && (state == ST_DATA)) begin
                we    <= 1'b1;
                waddr <= BASE_ADDR + {word_idx[29:0], 2'b00};
                wdata <= asm_word;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: two instances (default base and base 0x100) share stimulus.
module tb_imem_loader;

    localparam logic [31:0] BASE0    = 32'h0;
    localparam logic [31:0] BASE1    = 32'h100;
    localparam int          CAPACITY = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;

    logic        byte_ready0, we0, cpu_hold0, done0, error0;
    logic [31:0] waddr0, wdata0;
    logic        byte_ready1, we1, cpu_hold1, done1, error1;
    logic [31:0] waddr1, wdata1;

    always #5 clk = ~clk;

    imem_loader #(.ARRAY_SIZE(CAPACITY), .BASE_ADDR(BASE0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready0), .we(we0), .waddr(waddr0), .wdata(wdata0),
        .cpu_hold(cpu_hold0), .done(done0), .error(error0)
    );

    imem_loader #(.ARRAY_SIZE(CAPACITY), .BASE_ADDR(BASE1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready1), .we(we1), .waddr(waddr1), .wdata(wdata1),
        .cpu_hold(cpu_hold1), .done(done1), .error(error1)
    );

    typedef struct {
        int unsigned k;
        logic [31:0] data;
        bit          last;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] stim_words[$];
    int          errors      = 0;
    int          checks      = 0;
    int          acc_bytes   = 0;
    int          hold_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Both instances must show the same status; compare ready/hold/done/error for each.
    task automatic check_status(input string name, input bit r, input bit h, input bit d, input bit e);
        check(name, {24'd0, byte_ready0, cpu_hold0, done0, error0, byte_ready1, cpu_hold1, done1, error1},
                    {24'd0, r, h, d, e, r, h, d, e});
    endtask

    // Monitor: pops the scoreboard whenever a write strobe appears.
    always @(negedge clk) begin
        wr_t e;
        if (!rst) begin
            if (cpu_hold0) hold_cycles++;
            if (we0 || we1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_we", {30'd0, we1, we0}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("we_both", {30'd0, we1, we0}, 32'd3);
                    check("waddr_base0", waddr0, BASE0 + 32'(4 * e.k));
                    check("waddr_base1", waddr1, BASE1 + 32'(4 * e.k));
                    check("wdata0", wdata0, e.data);
                    check("wdata1", wdata1, e.data);
                    check("we_timing_bytes", 32'(acc_bytes), 32'(4 + 4 * (e.k + 1)));
                    if (e.last) begin
                        check("done_with_last_we", {30'd0, done1, done0}, 32'd3);
                        check("hold_low_last_we", {30'd0, cpu_hold1, cpu_hold0}, 32'd0);
                    end
                end
            end
        end
    end

    // Offer one byte (entered and left at a negedge); optional random idle gap first.
    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit with_start);
        int waited;
        if (gaps) begin
            byte_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        start      = with_start;
        waited     = 0;
        while (!byte_ready0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!byte_ready0) begin
            check("ready_timeout", 32'd0, 32'd1);
            byte_valid = 1'b0;
            start      = 1'b0;
        end else begin
            @(posedge clk);
            acc_bytes++;
            @(negedge clk);
            byte_valid = 1'b0;
            start      = 1'b0;
        end
    endtask

    // Full load: header n followed by stim_words; expected writes come from the stream rules.
    task automatic load(input logic [31:0] n, input bit gaps, input bit start_mid);
        acc_bytes   = 0;
        hold_cycles = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_status("start_enters_hdr", 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], gaps, 1'b0);
        if (n == 0) begin
            check_status("n0_done", 0, 0, 1, 0);
        end else if (n > CAPACITY) begin
            check_status("overflow_err", 0, 0, 0, 1);
        end else begin
            check_status("hdr_to_data", 1, 1, 0, 0);
            for (int k = 0; k < int'(n); k++) begin
                for (int j = 0; j < 4; j++) begin
                    if (j == 3) exp_q.push_back('{k: k, data: stim_words[k], last: (k == int'(n) - 1)});
                    send_byte(stim_words[k][8*j +: 8], gaps, start_mid && k == 0 && j == 1);
                end
            end
            check_status("load_done", 0, 0, 1, 0);
            if (!gaps) check("hold_cycles", 32'(hold_cycles), 32'(4 + 4 * int'(n)));
        end
        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("we_idle_after", {30'd0, we1, we0}, 32'd0);
    endtask

    task automatic random_words(input int n);
        stim_words.delete();
        for (int i = 0; i < n; i++) stim_words.push_back($urandom());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        #1;
        check_status("reset_status", 0, 0, 0, 0);
        check("reset_write_port", {we0 | we1, 31'd0} | waddr0 | wdata0 | waddr1 | wdata1, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_status("idle_status", 0, 0, 0, 0);

        // Reference program: two RISC-V instructions.
        stim_words = '{32'h0050_0513, 32'h0010_0593};
        load(32'd2, 1'b0, 1'b0);

        // Bytes offered in DONE are not accepted and nothing changes.
        byte_valid = 1'b1;
        byte_data  = 8'hAA;
        repeat (3) @(negedge clk);
        check_status("done_ignores_bytes", 0, 0, 1, 0);
        byte_valid = 1'b0;

        // Empty program.
        load(32'd0, 1'b0, 1'b0);

        // Overflow by one word, then a new start clears the error.
        load(32'd101, 1'b0, 1'b0);
        stim_words = '{32'h0050_0513, 32'h0010_0593};
        load(32'd2, 1'b1, 1'b0);

        // Exactly full memory is accepted.
        random_words(CAPACITY);
        load(32'(CAPACITY), 1'b0, 1'b0);

        // Huge header must compare unsigned.
        load(32'hFFFF_FFFF, 1'b1, 1'b0);

        // start pulse inside DATA is ignored.
        random_words(3);
        load(32'd3, 1'b0, 1'b1);

        // Reset after two bytes of word 1: word 0 is written, word 1 is discarded.
        stim_words = '{32'h1122_3344, 32'h5566_7788};
        acc_bytes  = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(i == 0 ? 8'd2 : 8'd0, 1'b0, 1'b0);
        exp_q.push_back('{k: 0, data: stim_words[0], last: 1'b0});
        for (int j = 0; j < 4; j++) send_byte(stim_words[0][8*j +: 8], 1'b0, 1'b0);
        for (int j = 0; j < 2; j++) send_byte(stim_words[1][8*j +: 8], 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_status("midload_reset_status", 0, 0, 0, 0);
        check("midload_reset_port", {we0 | we1, 31'd0} | waddr0 | wdata0 | waddr1 | wdata1, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_queue", 32'(exp_q.size()), 32'd0);
        check_status("after_reset_idle", 0, 0, 0, 0);
        random_words(2);
        load(32'd2, 1'b0, 1'b0);

        // Randomized loads with random stalls.
        for (int t = 0; t < 6; t++) begin
            int n;
            n = $urandom_range(1, 8);
            random_words(n);
            load(32'(n), 1'b1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
